// File: rtl/score_pkg.sv
// Shared types and helpers for the multi-player score arbiter.
//   game_state_t : game FSM encoding (IDLE=0, PLAY=1, OVER=2)
//   LIVES_W      : width of each player's lives counter
//   sat_add      : unsigned add clamped to (2^width)-1, for widths up to 31
package score_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // The sum is formed one bit wider than the operands so that a carry out is
  // never lost before the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << width) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/score_arbiter_mp_player_lane.sv
// One player's lane: saturating score, hit streak with periodic bonus,
// lives counter and a one-cycle bonus pulse.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : load a fresh game (score/streak 0, lives MAX_LIVES)
//   enable     : pulses are scored only while high (game in PLAY)
//   hit, miss  : one-cycle pulses; hit together with miss counts as a miss
//   score      : saturating score
//   lives      : lives remaining; 0 means eliminated, pulses are ignored
//   bonus_evt  : one-cycle pulse on the hit that completes a streak
module player_lane
  import score_pkg::*;
#(
  parameter int SCORE_W      = 16,
  parameter int STREAK_W     = 4,
  parameter int BONUS_THRESH = 5,
  parameter int BONUS_POINTS = 10,
  parameter int MAX_LIVES    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               bonus_evt
);

  localparam logic [STREAK_W:0] THRESH_V  = (STREAK_W + 1)'(BONUS_THRESH);
  localparam logic [31:0]       BONUS_INC = 32'(1 + BONUS_POINTS);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W:0]   streak_inc;
  logic                active;

  assign streak_inc = {1'b0, streak} + 1'b1;
  assign active     = enable && (lives != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      score     <= '0;
      streak    <= '0;
      lives     <= '0;
      bonus_evt <= 1'b0;
    end else if (clear) begin
      score     <= '0;
      streak    <= '0;
      lives     <= LIVES_W'(MAX_LIVES);
      bonus_evt <= 1'b0;
    end else begin
      bonus_evt <= 1'b0;
      if (active) begin
        if (miss) begin
          streak <= '0;
          lives  <= lives - LIVES_W'(1);
        end else if (hit) begin
          if (streak_inc == THRESH_V) begin
            // Bonus still clears the streak and pulses even when saturated.
            score     <= SCORE_W'(sat_add(32'(score), BONUS_INC, SCORE_W));
            streak    <= '0;
            bonus_evt <= 1'b1;
          end else begin
            score  <= SCORE_W'(sat_add(32'(score), 32'd1, SCORE_W));
            streak <= streak_inc[STREAK_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/score_arbiter_mp.sv
// Multi-player score arbiter: NUM_PLAYERS independent lanes gated by a game
// FSM that detects game over, latches the winner and tracks a high score.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears high_score too)
//   start       : pulse; starts a game from IDLE or OVER, ignored in PLAY
//   hit_pulse   : per-player hit pulses
//   miss_pulse  : per-player miss pulses
//   score       : packed scores, player i at [i*SCORE_W +: SCORE_W]
//   lives       : packed lives, player i at [i*4 +: 4]
//   bonus_evt   : per-player bonus pulses
//   state       : game state (IDLE=0, PLAY=1, OVER=2)
//   game_over   : high while in OVER
//   winner      : highest final score, lowest index on tie; valid in OVER
//   high_score  : best winning score since reset
module score_arbiter_mp
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 16,
  parameter int STREAK_W     = 4,
  parameter int BONUS_THRESH = 5,
  parameter int BONUS_POINTS = 10,
  parameter int MAX_LIVES    = 3,
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         hit_pulse,
  input  logic [NUM_PLAYERS-1:0]         miss_pulse,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]         bonus_evt,
  output logic [1:0]                     state,
  output logic                           game_over,
  output logic [WIN_W-1:0]               winner,
  output logic [SCORE_W-1:0]             high_score
);

  game_state_t        state_q;
  logic               lane_clear;
  logic               lane_en;
  logic               all_out;
  logic [SCORE_W-1:0] lane_score [NUM_PLAYERS];
  logic [LIVES_W-1:0] lane_lives [NUM_PLAYERS];
  logic [SCORE_W-1:0] best_score;
  logic [WIN_W-1:0]   best_idx;

  assign state      = state_q;
  assign lane_en    = (state_q == PLAY);
  assign lane_clear = start && (state_q != PLAY);

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    player_lane #(
      .SCORE_W     (SCORE_W),
      .STREAK_W    (STREAK_W),
      .BONUS_THRESH(BONUS_THRESH),
      .BONUS_POINTS(BONUS_POINTS),
      .MAX_LIVES   (MAX_LIVES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (lane_clear),
      .enable   (lane_en),
      .hit      (hit_pulse[i]),
      .miss     (miss_pulse[i]),
      .score    (lane_score[i]),
      .lives    (lane_lives[i]),
      .bonus_evt(bonus_evt[i])
    );
    assign score[i*SCORE_W +: SCORE_W] = lane_score[i];
    assign lives[i*LIVES_W +: LIVES_W] = lane_lives[i];
  end

  // Looks ahead one cycle: true when every lane will have 0 lives after this
  // edge, so OVER is entered on the same edge that takes the last life.
  // A lane losing its last life cannot score this cycle, so the current
  // scores are already the final ones.
  always_comb begin
    all_out = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!((lane_lives[i] == '0) ||
            (lane_lives[i] == LIVES_W'(1) && miss_pulse[i]))) begin
        all_out = 1'b0;
      end
    end
  end

  // Strict greater-than keeps the lowest index on a tie.
  always_comb begin
    best_score = lane_score[0];
    best_idx   = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (lane_score[i] > best_score) begin
        best_score = lane_score[i];
        best_idx   = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      game_over  <= 1'b0;
      winner     <= '0;
      high_score <= '0;
    end else begin
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q   <= PLAY;
            game_over <= 1'b0;
          end
        end
        PLAY: begin
          if (all_out) begin
            state_q   <= OVER;
            game_over <= 1'b1;
            winner    <= best_idx;
            if (best_score > high_score) high_score <= best_score;
          end
        end
        default: begin
          state_q   <= IDLE;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_arbiter_mp.sv
// Bench for score_arbiter_mp: instance 0 uses default parameters, instance 1
// uses SCORE_W=4 and MAX_LIVES=4 to reach saturation quickly.
module tb_score_arbiter_mp;

  logic       clk;
  logic       rst;
  logic       start_i [2];
  logic [1:0] hit_i   [2];
  logic [1:0] miss_i  [2];

  logic [31:0] score_a;
  logic [7:0]  lives_a;
  logic [1:0]  bonus_a;
  logic [1:0]  state_a;
  logic        go_a;
  logic [0:0]  win_a;
  logic [15:0] hs_a;

  logic [7:0]  score_b;
  logic [7:0]  lives_b;
  logic [1:0]  bonus_b;
  logic [1:0]  state_b;
  logic        go_b;
  logic [0:0]  win_b;
  logic [3:0]  hs_b;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  score_arbiter_mp dut_a (
    .clk(clk), .rst(rst), .start(start_i[0]),
    .hit_pulse(hit_i[0]), .miss_pulse(miss_i[0]),
    .score(score_a), .lives(lives_a), .bonus_evt(bonus_a),
    .state(state_a), .game_over(go_a), .winner(win_a), .high_score(hs_a)
  );

  score_arbiter_mp #(.SCORE_W(4), .MAX_LIVES(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_i[1]),
    .hit_pulse(hit_i[1]), .miss_pulse(miss_i[1]),
    .score(score_b), .lives(lives_b), .bonus_evt(bonus_b),
    .state(state_b), .game_over(go_b), .winner(win_b), .high_score(hs_b)
  );

  // ---------------- DUT accessors ----------------
  function automatic int d_score(int k, int p);
    return (k == 0) ? int'(score_a[p*16 +: 16]) : int'(score_b[p*4 +: 4]);
  endfunction
  function automatic int d_lives(int k, int p);
    return (k == 0) ? int'(lives_a[p*4 +: 4]) : int'(lives_b[p*4 +: 4]);
  endfunction
  function automatic int d_bonus(int k, int p);
    return (k == 0) ? int'(bonus_a[p]) : int'(bonus_b[p]);
  endfunction
  function automatic int d_state(int k);
    return (k == 0) ? int'(state_a) : int'(state_b);
  endfunction
  function automatic int d_go(int k);
    return (k == 0) ? int'(go_a) : int'(go_b);
  endfunction
  function automatic int d_win(int k);
    return (k == 0) ? int'(win_a) : int'(win_b);
  endfunction
  function automatic int d_hs(int k);
    return (k == 0) ? int'(hs_a) : int'(hs_b);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game rules applied per sampled cycle; state: 0 idle, 1 play, 2 over.
  int m_score  [2][2];
  int m_streak [2][2];
  int m_lives  [2][2];
  int m_bonus  [2][2];
  int m_state  [2];
  int m_win    [2];
  int m_hs     [2];
  int max_v    [2] = '{65535, 15};
  int max_l    [2] = '{3, 4};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0; m_win[k] = 0; m_hs[k] = 0;
        for (int p = 0; p < 2; p++) begin
          m_score[k][p] = 0; m_streak[k][p] = 0;
          m_lives[k][p] = 0; m_bonus[k][p] = 0;
        end
      end else if (m_state[k] != 1) begin
        for (int p = 0; p < 2; p++) m_bonus[k][p] = 0;
        if (start_i[k]) begin
          m_state[k] = 1;
          for (int p = 0; p < 2; p++) begin
            m_score[k][p] = 0; m_streak[k][p] = 0; m_lives[k][p] = max_l[k];
          end
        end
      end else begin
        int alive;
        int best;
        alive = 0;
        for (int p = 0; p < 2; p++) begin
          m_bonus[k][p] = 0;
          if (m_lives[k][p] > 0) begin
            if (miss_i[k][p]) begin
              m_streak[k][p] = 0;
              m_lives[k][p]  = m_lives[k][p] - 1;
            end else if (hit_i[k][p]) begin
              if (m_streak[k][p] + 1 == 5) begin
                m_score[k][p]  = m_score[k][p] + 11;
                m_streak[k][p] = 0;
                m_bonus[k][p]  = 1;
              end else begin
                m_score[k][p]  = m_score[k][p] + 1;
                m_streak[k][p] = m_streak[k][p] + 1;
              end
              if (m_score[k][p] > max_v[k]) m_score[k][p] = max_v[k];
            end
          end
          if (m_lives[k][p] > 0) alive++;
        end
        if (alive == 0) begin
          m_state[k] = 2;
          best = 0;
          for (int p = 1; p < 2; p++)
            if (m_score[k][p] > m_score[k][best]) best = p;
          m_win[k] = best;
          if (m_score[k][best] > m_hs[k]) m_hs[k] = m_score[k][best];
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("cmp_score k%0d p%0d", k, p), d_score(k, p), m_score[k][p]);
          chk($sformatf("cmp_lives k%0d p%0d", k, p), d_lives(k, p), m_lives[k][p]);
          chk($sformatf("cmp_bonus k%0d p%0d", k, p), d_bonus(k, p), m_bonus[k][p]);
        end
        chk($sformatf("cmp_state k%0d", k), d_state(k), m_state[k]);
        chk($sformatf("cmp_game_over k%0d", k), d_go(k), (m_state[k] == 2) ? 1 : 0);
        chk($sformatf("cmp_high_score k%0d", k), d_hs(k), m_hs[k]);
        if (m_state[k] == 2) chk($sformatf("cmp_winner k%0d", k), d_win(k), m_win[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of stimulus to instance k; the result is visible on return.
  task automatic step(input int k, input logic [1:0] h, input logic [1:0] m,
                      input logic s);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      start_i[j] = (j == k) ? s : 1'b0;
      hit_i[j]   = (j == k) ? h : 2'b00;
      miss_i[j]  = (j == k) ? m : 2'b00;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1;
    for (int j = 0; j < 2; j++) begin
      start_i[j] = 0; hit_i[j] = '0; miss_i[j] = '0;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, "_state"}, int'(state_a), 0);
    chk({tag, "_score"}, int'(score_a), 0);
    chk({tag, "_lives"}, int'(lives_a), 0);
    chk({tag, "_bonus"}, int'(bonus_a), 0);
    chk({tag, "_go"}, int'(go_a), 0);
    chk({tag, "_winner"}, int'(win_a), 0);
    chk({tag, "_hs"}, int'(hs_a), 0);
  endtask

  // ---------------- directed sequence ----------------
  int exp1 [5] = '{1, 2, 3, 4, 15};

  initial begin
    rst = 1;
    for (int j = 0; j < 2; j++) begin
      start_i[j] = 0; hit_i[j] = '0; miss_i[j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk_all_zero_a("rst");
    @(negedge clk);
    rst = 0;

    // start from IDLE
    step(0, 2'b00, 2'b00, 1'b1);
    chk("start_state", int'(state_a), 1);
    chk("start_lives", int'(lives_a), 8'h33);

    // player 0: five hits, bonus on the fifth
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b01, 2'b00, 1'b0);
      chk($sformatf("t1_score0_hit%0d", i), int'(score_a[15:0]), exp1[i]);
      chk($sformatf("t1_bonus0_hit%0d", i), int'(bonus_a[0]), (i == 4) ? 1 : 0);
    end
    step(0, 2'b00, 2'b00, 1'b0);
    chk("t1_bonus0_drop", int'(bonus_a[0]), 0);

    // player 1: 3 hits, miss, 5 hits -> 3 + 4 + 11 = 18
    repeat (3) step(0, 2'b10, 2'b00, 1'b0);
    step(0, 2'b00, 2'b10, 1'b0);
    chk("t2_lives1", int'(lives_a[7:4]), 2);
    chk("t2_score1_mid", int'(score_a[31:16]), 3);
    repeat (4) step(0, 2'b10, 2'b00, 1'b0);
    chk("t2_score1_4", int'(score_a[31:16]), 7);
    chk("t2_bonus1_4", int'(bonus_a[1]), 0);
    step(0, 2'b10, 2'b00, 1'b0);
    chk("t2_score1", int'(score_a[31:16]), 18);
    chk("t2_bonus1", int'(bonus_a[1]), 1);

    // hit and miss together counts as a miss
    step(0, 2'b01, 2'b01, 1'b0);
    chk("t3_score0", int'(score_a[15:0]), 15);
    chk("t3_lives0", int'(lives_a[3:0]), 2);

    // eliminate player 0, then its hits are ignored
    step(0, 2'b00, 2'b01, 1'b0);
    step(0, 2'b00, 2'b01, 1'b0);
    chk("elim_lives0", int'(lives_a[3:0]), 0);
    chk("elim_state", int'(state_a), 1);
    step(0, 2'b01, 2'b00, 1'b0);
    chk("elim_hit_ignored", int'(score_a[15:0]), 15);
    step(0, 2'b00, 2'b10, 1'b0);
    step(0, 2'b00, 2'b10, 1'b0);
    chk("over1_state", int'(state_a), 2);
    chk("over1_go", int'(go_a), 1);
    chk("over1_winner", int'(win_a), 1);
    chk("over1_hs", int'(hs_a), 18);
    step(0, 2'b11, 2'b11, 1'b0);
    chk("over1_ignore", int'(score_a), {16'd18, 16'd15});

    // reset in OVER clears the high score too
    do_rst();
    chk_all_zero_a("rst_over");

    // tie game at 7 each
    step(0, 2'b00, 2'b00, 1'b1);
    repeat (4) step(0, 2'b11, 2'b00, 1'b0);
    step(0, 2'b00, 2'b11, 1'b0);
    repeat (3) step(0, 2'b11, 2'b00, 1'b0);
    chk("tie_scores", int'(score_a), {16'd7, 16'd7});
    step(0, 2'b00, 2'b11, 1'b0);
    step(0, 2'b00, 2'b11, 1'b0);
    chk("tie_state", int'(state_a), 2);
    chk("tie_go", int'(go_a), 1);
    chk("tie_winner", int'(win_a), 0);
    chk("tie_hs", int'(hs_a), 7);
    step(0, 2'b11, 2'b00, 1'b0);
    chk("tie_over_ignore", int'(score_a), {16'd7, 16'd7});

    // restart keeps high score
    step(0, 2'b00, 2'b00, 1'b1);
    chk("restart_state", int'(state_a), 1);
    chk("restart_go", int'(go_a), 0);
    chk("restart_score", int'(score_a), 0);
    chk("restart_lives", int'(lives_a), 8'h33);
    chk("restart_hs", int'(hs_a), 7);
    repeat (2) step(0, 2'b11, 2'b00, 1'b0);
    step(0, 2'b01, 2'b00, 1'b1);
    chk("play_start_ignored", int'(score_a), {16'd2, 16'd3});
    chk("play_start_lives", int'(lives_a), 8'h33);

    // reset mid-PLAY
    do_rst();
    chk_all_zero_a("rst_play");

    // instance 1: saturation at SCORE_W=4
    step(1, 2'b00, 2'b00, 1'b1);
    chk("sat_lives", int'(lives_b), 8'h44);
    repeat (4) step(1, 2'b01, 2'b00, 1'b0);
    step(1, 2'b00, 2'b01, 1'b0);
    repeat (4) step(1, 2'b01, 2'b00, 1'b0);
    step(1, 2'b00, 2'b01, 1'b0);
    repeat (2) step(1, 2'b01, 2'b00, 1'b0);
    step(1, 2'b00, 2'b01, 1'b0);
    chk("sat_score10", int'(score_b[3:0]), 10);
    chk("sat_lives0", int'(lives_b[3:0]), 1);
    repeat (4) step(1, 2'b01, 2'b00, 1'b0);
    chk("sat_score14", int'(score_b[3:0]), 14);
    chk("sat_bonus_pre", int'(bonus_b[0]), 0);
    step(1, 2'b01, 2'b00, 1'b0);
    chk("sat_score15", int'(score_b[3:0]), 15);
    chk("sat_bonus", int'(bonus_b[0]), 1);
    step(1, 2'b01, 2'b00, 1'b0);
    chk("sat_hold", int'(score_b[3:0]), 15);
    chk("sat_bonus_drop", int'(bonus_b[0]), 0);

    step(1, 2'b00, 2'b00, 1'b0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/score_arbiter_mp.md
Name: score_arbiter_mp

Overview:
Multi-player successor to the single-player hit/miss score controller. Each of NUM_PLAYERS lanes keeps its own saturating score, hit streak with periodic bonus, and lives count. A small game FSM gates scoring, detects game over, and latches a winner and a persistent high score. It sits between the per-player hit/miss pulse generators and the score display/HUD logic.

Parameters:
NUM_PLAYERS, 2, number of independent player lanes (1..8)
SCORE_W, 16, score width per player; scores saturate at 2^SCORE_W-1
STREAK_W, 4, streak counter width; must satisfy BONUS_THRESH <= 2^STREAK_W-1
BONUS_THRESH, 5, consecutive hits that award a bonus (>=1)
BONUS_POINTS, 10, extra points added on the bonus hit, on top of the normal +1
MAX_LIVES, 3, lives loaded per player at game start (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; starts or restarts a game
hit_pulse  in  NUM_PLAYERS  per-player one-cycle hit pulses
miss_pulse  in  NUM_PLAYERS  per-player one-cycle miss pulses
score  out  NUM_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W]
lives  out  NUM_PLAYERS*4  packed lives remaining per player
bonus_evt  out  NUM_PLAYERS  one-cycle pulse when that player earns a bonus
state  out  2  game state encoding (IDLE=0, PLAY=1, OVER=2)
game_over  out  1  high while state==OVER
winner  out  max(1,$clog2(NUM_PLAYERS))  index of winning player, valid while game_over
high_score  out  SCORE_W  best final score since reset

Behaviour:
- Reset: state=IDLE; all scores, streaks, lives, bonus_evt, winner, high_score = 0; game_over=0.
- FSM: IDLE --start--> PLAY; PLAY --all lives==0--> OVER; OVER --start--> PLAY. start in PLAY is ignored.
- Entering PLAY (the cycle after start is sampled): scores=0, streaks=0, lives=MAX_LIVES for every player; high_score is kept.
- Pulses are ignored in IDLE and OVER, and for any player whose lives==0 (eliminated).
- Per active player in PLAY, evaluated in the cycle the pulse is sampled, registered result visible next cycle:
  - hit only: score += 1, streak += 1. If streak+1 == BONUS_THRESH: score += 1+BONUS_POINTS instead, streak=0, bonus_evt=1 for one cycle.
  - miss only: streak=0; lives -= 1.
  - hit and miss in the same cycle: treated as a miss only.
- Score arithmetic is computed one bit wider, then clamps to 2^SCORE_W-1. No wrap-around. A bonus hit still clears the streak and pulses bonus_evt when the score is saturated.
- Lanes are independent. Simultaneous events on different players are all applied in the same cycle.
- Game over: the cycle in which the last remaining life is lost is also the last PLAY cycle. On the next edge, state=OVER, game_over=1, and winner and high_score are latched.
- Winner is the highest final score. On a tie, the lowest index wins.
- high_score = max(previous high_score, winner's score), updated only on entry to OVER.
- Scores and lives hold their final values throughout OVER until the next start.
- rst takes priority over every input in any state, including mid-game. It also clears high_score.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package score_pkg holds:
  - game_state_t enum (IDLE, PLAY, OVER);
  - LIVES_W=4;
  - a saturating-add function sat_add(a, b, width).
- Sub-module player_lane holds one player's score, streak, lives and bonus_evt. It takes enable, clear, hit and miss, and is instantiated NUM_PLAYERS times by generate.
- The top level contains the FSM, the all-eliminated detect, the winner/tie reduction, and the high_score register.

Test Plan:
- rst, start, then player 0 hits on 5 consecutive cycles -> score0 = 1,2,3,4,15; bonus_evt[0] pulses once, one cycle after the 5th hit; streak returns to 0.
- PLAY, player 1 gets 3 hits, 1 miss, then 5 hits -> miss resets the streak, lives1=2, final score1 = 3+4+11 = 18.
- hit_pulse[0] and miss_pulse[0] asserted in the same cycle -> score0 unchanged, streak 0, lives0 decremented by 1.
- SCORE_W=4, player 0 at score 14 with streak 4, then a hit -> score0=15 (saturated), bonus_evt[0]=1, streak 0; a further hit keeps score0=15.
- Both players drained to 0 lives with score0=7 and score1=7 -> state=OVER, game_over=1, winner=0, high_score=7. start -> PLAY, scores 0, lives 3, high_score still 7. Pulses in OVER are ignored.
- rst mid-PLAY with nonzero scores and high_score=7 -> the next cycle shows IDLE and all outputs 0, including high_score.
